// File: rtl/uart_tx_fifo.sv
// UART transmit path: 2**FIFO_WIDTH byte FIFO, baud divider and frame serializer (8N1).
// Optional even-parity bit (8E1) is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Load_Data,
  input  logic                 BIST_Mode,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic [FIFO_WIDTH:0]  FIFO_Count
);
  localparam int DEPTH  = 1 << FIFO_WIDTH;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]      BIT_ONE   = BIT_W'(1);
  localparam logic [FIFO_WIDTH:0]   CNT_FULL  = (FIFO_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE   = (FIFO_WIDTH + 1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE   = FIFO_WIDTH'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [FIFO_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]    count_q, count_d;
  logic                   empty_q, empty_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic                   pop;
  logic                   wr_req;
  logic                   wr_accept;
  logic                   baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign wr_req    = Load_Data && !BIST_Mode;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty_q && !BIST_Mode) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Popping here chains the next start bit directly onto this stop bit.
          if (!empty_q && !BIST_Mode) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end
  end

  // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
  always_comb begin
    wr_accept = wr_req && (!full_q || pop);
    wr_ptr_d  = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    count_d   = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_accept && pop) begin
      count_d = count_q - CNT_ONE;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    ovf_d   = ovf_q;
    if (pop) begin
      ovf_d = 1'b0;
    end else if (wr_req && !wr_accept) begin
      ovf_d = 1'b1;
    end
  end

  // Line level and busy are derived from the next state so both come straight from flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= Tx_Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign Tx            = tx_q;
  assign Tx_Busy       = busy_q;
  assign FIFO_Empty    = empty_q;
  assign FIFO_Full     = full_q;
  assign FIFO_Overflow = ovf_q;
  assign FIFO_Count    = count_q;

endmodule
